pipelined_mac_param: RTL and testbench

Parametrised signed multiply-accumulate unit built around an S-stage pipelined multiplier. Successor to the fixed 14-bit, six-stage MAC. It adds:
- generic operand, accumulator and pipeline-depth parameters;
- a per-sample accumulator restart tag;
- selectable saturating or wrapping accumulation, with a sticky overflow flag.

It sits in the convolution datapath as the per-channel dot-product engine, taking one operand pair per cycle with no backpressure.

---
 rtl/pipelined_mac_param.sv | 100 ++++++++++
 tb/tb_pipelined_mac_param.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_mac_param.sv
// Signed multiply-accumulate engine: S-stage pipelined multiplier feeding a
// restartable accumulator with selectable saturating or wrapping overflow.
module pipelined_mac_param #(
  parameter int unsigned WIDTH       = 14,
  parameter int unsigned ACC_WIDTH   = 28,
  parameter int unsigned MULT_STAGES = 6,
  parameter bit          SATURATE    = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  input  logic                        valid_in,
  input  logic                        clear_acc,
  output logic signed [ACC_WIDTH-1:0] f,
  output logic                        valid_out,
  output logic                        overflow
);

  localparam int unsigned ProdW = 2 * WIDTH;
  localparam int unsigned SumW  = ACC_WIDTH + 1;

  localparam logic signed [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH - 1){1'b0}}};

  logic signed [ProdW-1:0]     prod_q [MULT_STAGES];
  logic [MULT_STAGES-1:0]      valid_q;
  logic [MULT_STAGES-1:0]      clear_q;

  logic signed [ACC_WIDTH-1:0] f_q, f_d;
  logic                        overflow_q, overflow_d;
  logic                        valid_out_q, valid_out_d;

  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [SumW-1:0]      sum;
  logic                        sum_ovf;

  // Product is formed in stage 1 and delayed; synthesis retiming spreads the
  // multiplier across the trailing registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      clear_q <= '0;
      for (int i = 0; i < MULT_STAGES; i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_in;
      clear_q[0] <= valid_in & clear_acc;
      prod_q[0]  <= ProdW'(a) * ProdW'(b);
      for (int i = 1; i < MULT_STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
        clear_q[i] <= clear_q[i-1];
        prod_q[i]  <= prod_q[i-1];
      end
    end
  end

  always_comb begin
    prod_ext    = ACC_WIDTH'(prod_q[MULT_STAGES-1]);
    sum         = SumW'(f_q) + SumW'(prod_ext);
    // Top two bits disagree exactly when the sum left the accumulator range.
    sum_ovf     = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    f_d         = f_q;
    overflow_d  = overflow_q;
    valid_out_d = valid_q[MULT_STAGES-1];
    if (valid_q[MULT_STAGES-1]) begin
      if (clear_q[MULT_STAGES-1]) begin
        f_d        = prod_ext;
        overflow_d = 1'b0;
      end else if (sum_ovf) begin
        overflow_d = 1'b1;
        if (SATURATE) begin
          f_d = sum[ACC_WIDTH] ? AccMin : AccMax;
        end else begin
          f_d = sum[ACC_WIDTH-1:0];
        end
      end else begin
        f_d = sum[ACC_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_q         <= '0;
      overflow_q  <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      f_q         <= f_d;
      overflow_q  <= overflow_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign f         = f_q;
  assign overflow  = overflow_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_pipelined_mac_param.sv
// Scoreboard bench for pipelined_mac_param: saturating and wrapping instances
// share stimulus; a negedge monitor pops hand-computed expectations per pulse.
module tb_pipelined_mac_param;

  localparam int unsigned Lat = 6;

  logic                clk;
  logic                reset;
  logic signed [13:0]  a, b;
  logic                valid_in, clear_acc;
  logic signed [27:0]  f_s, f_w;
  logic                vo_s, vo_w, ov_s, ov_w;

  typedef struct {
    longint      f;
    logic        ovf;
    int unsigned cyc;
  } exp_t;

  exp_t        qs[$];
  exp_t        qw[$];
  int unsigned cyc;
  int          total;
  int          bad;
  longint      last_f[2];
  logic        last_ov[2];

  pipelined_mac_param #(
    .WIDTH(14), .ACC_WIDTH(28), .MULT_STAGES(Lat), .SATURATE(1'b1)
  ) u_sat (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_acc(clear_acc),
    .f(f_s), .valid_out(vo_s), .overflow(ov_s)
  );

  pipelined_mac_param #(
    .WIDTH(14), .ACC_WIDTH(28), .MULT_STAGES(Lat), .SATURATE(1'b0)
  ) u_wrap (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_acc(clear_acc),
    .f(f_w), .valid_out(vo_w), .overflow(ov_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic mon(input int idx, input logic vo, input longint fv, input logic ov);
    exp_t  e;
    string tag;
    tag = (idx == 0) ? "sat" : "wrap";
    if (vo) begin
      if ((idx == 0 && qs.size() == 0) || (idx == 1 && qw.size() == 0)) begin
        total++;
        bad++;
        $display("FAIL %s_unexpected_pulse: got f=%0d expected no pulse", tag, fv);
      end else begin
        if (idx == 0) e = qs.pop_front();
        else          e = qw.pop_front();
        check($sformatf("%s_f", tag), fv, e.f);
        check($sformatf("%s_ovf", tag), longint'(ov), longint'(e.ovf));
        check($sformatf("%s_latency_cyc", tag), longint'(cyc), longint'(e.cyc));
      end
      last_f[idx]  = fv;
      last_ov[idx] = ov;
    end else begin
      check($sformatf("%s_f_hold", tag), fv, last_f[idx]);
      check($sformatf("%s_ovf_hold", tag), longint'(ov), longint'(last_ov[idx]));
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        last_f[i]  = 0;
        last_ov[i] = 1'b0;
      end
      check("rst_hold_vo", longint'(vo_s | vo_w), 0);
    end else begin
      mon(0, vo_s, longint'(f_s), ov_s);
      mon(1, vo_w, longint'(f_w), ov_w);
    end
  end

  task automatic send(input int av, input int bv, input logic clr,
                      input longint fs, input logic os, input longint fw, input logic ow);
    exp_t e;
    @(posedge clk);
    #1;
    a         = 14'(av);
    b         = 14'(bv);
    valid_in  = 1'b1;
    clear_acc = clr;
    e.cyc = cyc + 1 + Lat;
    e.f = fs; e.ovf = os; qs.push_back(e);
    e.f = fw; e.ovf = ow; qw.push_back(e);
  endtask

  task automatic bubble(input logic clr);
    @(posedge clk);
    #1;
    valid_in  = 1'b0;
    clear_acc = clr;
    a         = '0;
    b         = '0;
  endtask

  task automatic idle(input int n);
    bubble(1'b0);
    repeat (n) @(posedge clk);
  endtask

  task automatic check_zero(input string name);
    check({name, "_f_sat"}, longint'(f_s), 0);
    check({name, "_f_wrap"}, longint'(f_w), 0);
    check({name, "_vo"}, longint'(vo_s | vo_w), 0);
    check({name, "_ovf"}, longint'(ov_s | ov_w), 0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    valid_in  = 1'b0;
    clear_acc = 1'b0;
    a         = '0;
    b         = '0;
    #2;
    check_zero("reset_state");
    #21;
    reset = 1'b1;

    // Basic latency
    send(3, -4, 1'b1, -12, 1'b0, -12, 1'b0);
    idle(10);

    // Back-to-back
    send(100, 200, 1'b1, 20000, 1'b0, 20000, 1'b0);
    send(100, 200, 1'b0, 40000, 1'b0, 40000, 1'b0);
    send(100, 200, 1'b0, 60000, 1'b0, 60000, 1'b0);
    send(100, 200, 1'b0, 80000, 1'b0, 80000, 1'b0);
    idle(10);

    // Bubble carrying a stray clear must not restart accumulation
    send(5, 5, 1'b1, 25, 1'b0, 25, 1'b0);
    bubble(1'b1);
    send(2, -3, 1'b0, 19, 1'b0, 19, 1'b0);
    idle(10);

    // Saturation vs wrap on the most negative operands
    send(-8192, -8192, 1'b1, 67108864, 1'b0, 67108864, 1'b0);
    send(-8192, -8192, 1'b0, 134217727, 1'b1, -134217728, 1'b1);
    send(-8192, -8192, 1'b0, 134217727, 1'b1, -67108864, 1'b1);
    idle(10);
    send(1, 1, 1'b1, 1, 1'b0, 1, 1'b0);
    idle(10);
    check("pre_reset_f_nonzero", longint'(f_s), 1);

    // Async reset mid-flight
    send(9, 9, 1'b1, 81, 1'b0, 81, 1'b0);
    send(9, 9, 1'b0, 162, 1'b0, 162, 1'b0);
    send(9, 9, 1'b0, 243, 1'b0, 243, 1'b0);
    #5;
    reset = 1'b0;
    #1;
    check_zero("async_reset");
    valid_in  = 1'b0;
    clear_acc = 1'b0;
    qs.delete();
    qw.delete();
    #19;
    reset = 1'b1;
    repeat (15) @(posedge clk);
    send(7, 7, 1'b1, 49, 1'b0, 49, 1'b0);
    idle(12);

    check("sat_queue_drained", longint'(qs.size()), 0);
    check("wrap_queue_drained", longint'(qw.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
